// File: rtl/pll_shift_scheduler.sv
// Command queue plus sequencer that issues phase-shift steps to two dynamic-phase PLLs
// sharing a single phaseupdown line; one command is executed at a time.
module pll_shift_scheduler #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned PULSE_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_pll,
  input  logic [2:0] i_cmd_counter,
  input  logic       i_cmd_updown,
  input  logic [7:0] i_cmd_steps,
  input  logic [1:0] i_pll_locked,
  input  logic [1:0] i_phasedone,
  output logic [1:0] o_phasestep,
  output logic [2:0] o_phasecounterselect_1,
  output logic [2:0] o_phasecounterselect_2,
  output logic       o_phaseupdown,
  output logic       o_busy,
  output logic       o_cmd_done,
  output logic       o_timeout,
  output logic [2:0] o_current_state
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned SW = $clog2(SETUP_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETUP   = 3'd2,
    S_STEP    = 3'd3,
    S_WAIT_LO = 3'd4,
    S_WAIT_HI = 3'd5,
    S_RETIRE  = 3'd6
  } state_t;

  state_t state, state_next;

  logic [12:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  logic          cur_pll, cur_up;
  logic [2:0]    cur_ctr;
  logic [7:0]    cur_steps, step_cnt;
  logic [TW-1:0] timer;
  logic [SW-1:0] setup_cnt;
  logic          lock_sel, done_sel, timer_max, timeout_hit;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign o_cmd_ready = !full;
  assign push        = i_cmd_valid && !full;
  assign pop         = (state == S_IDLE) && !empty;

  assign lock_sel  = i_pll_locked[cur_pll];
  assign done_sel  = i_phasedone[cur_pll];
  assign timer_max = (timer == TW'(TIMEOUT_CYCLES - 1));

  assign o_phasestep     = (state == S_STEP) ? (cur_pll ? 2'b10 : 2'b01) : 2'b00;
  assign o_busy          = (state != S_IDLE) || !empty;
  assign o_cmd_done      = (state == S_RETIRE);
  assign o_current_state = state;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_cmd_pll, i_cmd_counter, i_cmd_updown, i_cmd_steps};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:   if (!empty) state_next = S_LOAD;
      S_LOAD:   state_next = (cur_steps == '0) ? S_RETIRE : S_SETUP;
      S_SETUP: begin
        if (lock_sel && setup_cnt == SW'(SETUP_CYCLES - 1)) state_next = S_STEP;
        else if (timer_max) begin
          state_next  = S_RETIRE;
          timeout_hit = 1'b1;
        end
      end
      S_STEP:   if (timer == TW'(PULSE_CYCLES - 1)) state_next = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!done_sel) state_next = S_WAIT_HI;
        else if (timer_max) begin
          state_next  = S_RETIRE;
          timeout_hit = 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (done_sel) state_next = (step_cnt == 8'd1) ? S_RETIRE : S_SETUP;
        else if (timer_max) begin
          state_next  = S_RETIRE;
          timeout_hit = 1'b1;
        end
      end
      S_RETIRE: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // timer doubles as the phasestep width counter since it restarts on every state entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                  <= S_IDLE;
      timer                  <= '0;
      setup_cnt              <= '0;
      cur_pll                <= 1'b0;
      cur_ctr                <= '0;
      cur_up                 <= 1'b0;
      cur_steps              <= '0;
      step_cnt               <= '0;
      o_phasecounterselect_1 <= '0;
      o_phasecounterselect_2 <= '0;
      o_phaseupdown          <= 1'b0;
      o_timeout              <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= (state_next != state) ? '0 : timer + TW'(1);
      setup_cnt <= (state == S_SETUP && state_next == S_SETUP && lock_sel) ?
                   setup_cnt + SW'(1) : '0;
      if (pop) {cur_pll, cur_ctr, cur_up, cur_steps} <= mem[rd_ptr];
      if (state == S_LOAD && cur_steps != '0) begin
        if (cur_pll) o_phasecounterselect_2 <= cur_ctr;
        else         o_phasecounterselect_1 <= cur_ctr;
        o_phaseupdown <= cur_up;
        step_cnt      <= cur_steps;
      end
      if (state == S_WAIT_HI && done_sel) step_cnt <= step_cnt - 8'd1;
      if (timeout_hit) o_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_shift_scheduler.sv
// Directed bench for pll_shift_scheduler with a behavioural phasedone model per PLL.
module tb_pll_shift_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic       i_cmd_pll = 1'b0;
  logic [2:0] i_cmd_counter = '0;
  logic       i_cmd_updown = 1'b0;
  logic [7:0] i_cmd_steps = '0;
  logic [1:0] i_pll_locked = 2'b11;
  logic [1:0] i_phasedone = 2'b11;
  logic [1:0] o_phasestep;
  logic [2:0] o_phasecounterselect_1, o_phasecounterselect_2;
  logic       o_phaseupdown, o_busy, o_cmd_done, o_timeout;
  logic [2:0] o_current_state;

  always #5 i_clk = ~i_clk;

  pll_shift_scheduler #(
    .FIFO_DEPTH(4), .SETUP_CYCLES(2), .PULSE_CYCLES(2), .TIMEOUT_CYCLES(1024)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_pll(i_cmd_pll), .i_cmd_counter(i_cmd_counter), .i_cmd_updown(i_cmd_updown),
    .i_cmd_steps(i_cmd_steps), .i_pll_locked(i_pll_locked), .i_phasedone(i_phasedone),
    .o_phasestep(o_phasestep), .o_phasecounterselect_1(o_phasecounterselect_1),
    .o_phasecounterselect_2(o_phasecounterselect_2), .o_phaseupdown(o_phaseupdown),
    .o_busy(o_busy), .o_cmd_done(o_cmd_done), .o_timeout(o_timeout),
    .o_current_state(o_current_state)
  );

  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int         p0;
    int         p1;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       ud;
  } rec_t;

  rec_t       recs[$];
  int         pc0 = 0, pc1 = 0, tot0 = 0, tot1 = 0;
  int         run[2] = '{0, 0};
  int         lo[2] = '{0, 0};
  int         bad_width = 0, both_hi = 0, done_cnt = 0, wl_run = 0, last_wl = 0;
  logic [1:0] ps_prev = 2'b00;
  logic [1:0] hold_hi = 2'b00;

  // PLL model: phasedone goes low for 4 cycles after each phasestep pulse; monitor records retires
  always begin
    @(posedge i_clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (o_phasestep[p] && !ps_prev[p]) begin
        if (p == 0) begin pc0++; tot0++; end
        else        begin pc1++; tot1++; end
      end
      if (!o_phasestep[p] && ps_prev[p]) lo[p] = 4;
      if (o_phasestep[p]) run[p]++;
      else if (run[p] != 0) begin
        if (run[p] != 2) bad_width++;
        run[p] = 0;
      end
      i_phasedone[p] = hold_hi[p] ? 1'b1 : (lo[p] > 0 ? 1'b0 : 1'b1);
      if (lo[p] > 0) lo[p]--;
    end
    if (&o_phasestep) both_hi++;
    if (o_current_state == 3'd4) wl_run++;
    else if (wl_run != 0) begin
      last_wl = wl_run;
      wl_run  = 0;
    end
    if (o_cmd_done) begin
      done_cnt++;
      recs.push_back('{pc0, pc1, o_phasecounterselect_1, o_phasecounterselect_2, o_phaseupdown});
      pc0 = 0;
      pc1 = 0;
    end
    ps_prev = o_phasestep;
  end

  task automatic push(input logic pll, input logic [2:0] ctr, input logic up,
                      input logic [7:0] steps, input int max_wait);
    bit acc;
    int n;
    n = 0;
    i_cmd_pll     = pll;
    i_cmd_counter = ctr;
    i_cmd_updown  = up;
    i_cmd_steps   = steps;
    i_cmd_valid   = 1'b1;
    forever begin
      acc = o_cmd_ready;
      @(posedge i_clk);
      @(negedge i_clk);
      if (acc) break;
      n++;
      if (n >= max_wait) begin
        check("push_accept", 0, 1);
        break;
      end
    end
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_recs(input int n, input int max_wait, input string tag);
    int k;
    k = 0;
    while (recs.size() < n && k < max_wait) begin
      @(negedge i_clk);
      k++;
    end
    check(tag, recs.size(), n);
  endtask

  task automatic wait_state(input logic [2:0] st, input int max_wait, input string tag);
    int k;
    k = 0;
    while (o_current_state != st && k < max_wait) begin
      @(negedge i_clk);
      k++;
    end
    check(tag, o_current_state, st);
  endtask

  logic       t2_pll[6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [2:0] t2_ctr[6]   = '{3'd1, 3'd2, 3'd5, 3'd7, 3'd4, 3'd3};
  logic       t2_up[6]    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] t2_steps[6] = '{8'd2, 8'd1, 8'd1, 8'd3, 8'd2, 8'd1};

  initial begin
    logic [2:0] sel_exp[2];
    int base, s0, s1;

    repeat (3) @(negedge i_clk);
    check("rst_ready", o_cmd_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_state", o_current_state, 0);
    check("rst_step", o_phasestep, 0);
    check("rst_sel", {o_phasecounterselect_1, o_phasecounterselect_2}, 0);
    check("rst_misc", {o_phaseupdown, o_cmd_done, o_timeout}, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // single command, three steps on pll_0_3
    recs.delete();
    push(1'b0, 3'd3, 1'b1, 8'd3, 10);
    wait_recs(1, 300, "t1_retired");
    repeat (10) @(negedge i_clk);
    check("t1_done_count", recs.size(), 1);
    if (recs.size() > 0) begin
      check("t1_pulses0", recs[0].p0, 3);
      check("t1_pulses1", recs[0].p1, 0);
      check("t1_sel1", recs[0].s1, 3);
      check("t1_updown", recs[0].ud, 1);
    end
    check("t1_width", bad_width, 0);
    check("t1_onehot", both_hi, 0);

    // zero-step command: IDLE, LOAD, RETIRE with no pulse and no select change
    s0 = tot0 + tot1;
    push(1'b1, 3'd5, 1'b0, 8'd0, 10);
    check("t3_idle", o_current_state, 0);
    check("t3_done_early", o_cmd_done, 0);
    @(negedge i_clk);
    check("t3_load", o_current_state, 1);
    @(negedge i_clk);
    check("t3_retire", o_current_state, 6);
    check("t3_done", o_cmd_done, 1);
    @(negedge i_clk);
    check("t3_back_idle", o_current_state, 0);
    check("t3_done_once", o_cmd_done, 0);
    check("t3_no_pulse", tot0 + tot1, s0);
    check("t3_sel2_held", o_phasecounterselect_2, 0);
    check("t3_timeout", o_timeout, 0);

    // queue fill, full back-pressure, in-order retirement
    repeat (3) @(negedge i_clk);
    recs.delete();
    base = done_cnt;
    for (int i = 0; i < 5; i++) push(t2_pll[i], t2_ctr[i], t2_up[i], t2_steps[i], 10);
    check("t2_full_ready", o_cmd_ready, 0);
    check("t2_busy", o_busy, 1);
    push(t2_pll[5], t2_ctr[5], t2_up[5], t2_steps[5], 500);
    check("t2_accept_after_pop", done_cnt - base, 1);
    wait_recs(6, 3000, "t2_retired");
    sel_exp[0] = 3'd3;
    sel_exp[1] = 3'd0;
    for (int i = 0; i < 6 && i < recs.size(); i++) begin
      sel_exp[t2_pll[i]] = t2_ctr[i];
      check($sformatf("t2_c%0d_sel1", i), recs[i].s1, sel_exp[0]);
      check($sformatf("t2_c%0d_sel2", i), recs[i].s2, sel_exp[1]);
      check($sformatf("t2_c%0d_p0", i), recs[i].p0, t2_pll[i] ? 0 : t2_steps[i]);
      check($sformatf("t2_c%0d_p1", i), recs[i].p1, t2_pll[i] ? t2_steps[i] : 0);
      check($sformatf("t2_c%0d_ud", i), recs[i].ud, t2_up[i]);
    end
    check("t2_width", bad_width, 0);
    check("t2_onehot", both_hi, 0);

    // lock loss holds the sequencer in SETUP
    repeat (3) @(negedge i_clk);
    recs.delete();
    i_pll_locked = 2'b10;
    push(1'b0, 3'd6, 1'b0, 8'd1, 10);
    wait_state(3'd2, 50, "t5_enter_setup");
    s0 = tot0;
    repeat (50) @(negedge i_clk);
    check("t5_held_state", o_current_state, 2);
    check("t5_no_pulse", tot0, s0);
    i_pll_locked = 2'b11;
    @(negedge i_clk);
    check("t5_lock_plus1", o_phasestep, 2'b00);
    @(negedge i_clk);
    check("t5_lock_plus2", o_phasestep, 2'b01);
    wait_recs(1, 100, "t5_retired");
    if (recs.size() > 0) check("t5_pulses0", recs[0].p0, 1);

    // stuck phasedone on pll_4_7 aborts after 1024 cycles in WAIT_LO
    repeat (3) @(negedge i_clk);
    recs.delete();
    hold_hi = 2'b10;
    push(1'b1, 3'd6, 1'b0, 8'd2, 10);
    push(1'b0, 3'd2, 1'b1, 8'd1, 10);
    wait_recs(1, 1500, "t4_aborted");
    check("t4_timeout", o_timeout, 1);
    check("t4_wait_lo_len", last_wl, 1024);
    if (recs.size() > 0) begin
      check("t4_pulses1", recs[0].p1, 1);
      check("t4_sel2", recs[0].s2, 6);
    end
    hold_hi = 2'b00;
    wait_recs(2, 200, "t4_next_ran");
    if (recs.size() > 1) check("t4_next_pulses0", recs[1].p0, 1);
    check("t4_sticky", o_timeout, 1);

    // reset during WAIT_HI with two commands queued
    repeat (3) @(negedge i_clk);
    recs.delete();
    push(1'b0, 3'd2, 1'b1, 8'd3, 10);
    push(1'b1, 3'd1, 1'b1, 8'd2, 10);
    push(1'b0, 3'd7, 1'b0, 8'd1, 10);
    wait_state(3'd5, 100, "t6_wait_hi");
    i_rst = 1'b1;
    @(negedge i_clk);
    check("t6_state", o_current_state, 0);
    check("t6_busy", o_busy, 0);
    check("t6_ready", o_cmd_ready, 1);
    check("t6_step", o_phasestep, 0);
    check("t6_sel", {o_phasecounterselect_1, o_phasecounterselect_2}, 0);
    check("t6_misc", {o_phaseupdown, o_cmd_done, o_timeout}, 0);
    i_rst = 1'b0;
    s1 = tot0 + tot1;
    repeat (40) @(negedge i_clk);
    check("t6_no_resume_pulse", tot0 + tot1, s1);
    check("t6_no_resume_state", o_current_state, 0);
    check("t6_no_retire", recs.size(), 0);
    check("t6_idle_busy", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d vectors", n_vec);
    $fatal(1);
  end

endmodule
